conv_win_gen: RTL

- Streaming 3x3 window generator directly downstream of the input interface. It pops pixels from the input-interface FIFO, keeps the two previous image rows in internal line memories, and emits one 3x3 neighbourhood per interior pixel to the convolution datapath.
- Output uses a valid/ready handshake. Only "valid" convolution is produced (no padding), so the output frame is (cfg_width-2) x (cfg_height-2).

---
 rtl/conv_win_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/conv_win_gen.sv
// Streaming 3x3 window generator: pops pixels from the input FIFO and keeps two
// line memories plus a 3x3 shift window. It emits one window per interior pixel.
module conv_win_gen #(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XB-1:0]   cfg_width,
  input  logic [YB-1:0]   cfg_height,
  input  logic            inf_avail,
  input  logic [PB-1:0]   inf_data,
  input  logic [XB-1:0]   col_count,
  input  logic [YB-1:0]   row_count,
  output logic            inf_rd,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*PB-1:0] win_data,
  output logic [XB-1:0]   win_x,
  output logic [YB-1:0]   win_y,
  output logic            win_last
);

  localparam int DEPTH = 1 << XB;

  logic [PB-1:0]   lb0 [DEPTH];
  logic [PB-1:0]   lb1 [DEPTH];
  logic [PB-1:0]   win_p0 [3][3];
  logic [PB-1:0]   shifted [3][3];
  logic [9*PB-1:0] shifted_flat;
  logic [PB-1:0]   lb0_rd;
  logic [PB-1:0]   lb1_rd;
  logic [XB-1:0]   last_col;
  logic [YB-1:0]   last_row;
  logic            free;
  logic            pop;
  logic            emit;

  assign free     = ~win_valid | win_ready;
  assign inf_rd   = inf_avail & free;
  assign pop      = inf_rd;
  assign lb0_rd   = lb0[col_count];
  assign lb1_rd   = lb1[col_count];
  // Border rows/columns still feed the line memories and window but never emit.
  assign emit     = pop & (col_count >= XB'(2)) & (row_count >= YB'(2));
  assign last_col = cfg_width - XB'(1);
  assign last_row = cfg_height - YB'(1);

  always_ff @(posedge clk) begin
    if (pop) begin
      lb0[col_count] <= lb1_rd;
      lb1[col_count] <= inf_data;
    end
  end

  always_comb begin
    shifted_flat = '0;
    for (int dy = 0; dy < 3; dy++) begin
      shifted[dy][0] = win_p0[dy][1];
      shifted[dy][1] = win_p0[dy][2];
    end
    shifted[0][2] = lb0_rd;
    shifted[1][2] = lb1_rd;
    shifted[2][2] = inf_data;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        shifted_flat[(dy*3+dx)*PB +: PB] = shifted[dy][dx];
      end
    end
  end

  // Stage p0: window column shift on every pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          win_p0[dy][dx] <= '0;
        end
      end
    end else if (pop) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          win_p0[dy][dx] <= shifted[dy][dx];
        end
      end
    end
  end

  // Stage p1: output slot; a new window may replace an accepted one in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_x     <= '0;
      win_y     <= '0;
      win_last  <= 1'b0;
    end else if (emit) begin
      win_valid <= 1'b1;
      win_data  <= shifted_flat;
      win_x     <= col_count - XB'(1);
      win_y     <= row_count - YB'(1);
      win_last  <= (col_count == last_col) && (row_count == last_row);
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule
